// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage.
// Resolves the branch, runs byte/half/word loads and stores over a req/ack
// data-memory bus with wait states and timeout, and registers MEM/WB.
// Optional build macro: MEM_PERF_CNT_EN enables the perf_stalls/perf_accesses counters.
//
// Bus handshake: dmem_req is held high until a one-cycle dmem_ack pulse
// completes the access; address, lanes and data stay stable meanwhile
// because stall_MEM freezes the upstream latches. An ack seen without an
// outstanding request is ignored. The FSM state is visible as the 'state' signal.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluresult_MEM,
    input  logic [31:0] writedata_MEM,
    input  logic [4:0]  writereg_MEM,
    input  logic        zero_MEM,
    input  logic [31:0] pcbranch_MEM,
    input  logic        branch_MEM,
    input  logic        memread_MEM,
    input  logic        memwrite_MEM,
    input  logic        regwrite_MEM,
    input  logic        memtoreg_MEM,
    input  logic [1:0]  memsize_MEM,
    input  logic        memsigned_MEM,
    output logic        pcsrc_MEM,
    output logic [31:0] pctarget_MEM,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        regwrite_WB,
    output logic        memtoreg_WB,
    output logic [31:0] readdata_WB,
    output logic [31:0] aluresult_WB,
    output logic [4:0]  writereg_WB,
    output logic        misalign_WB,
    output logic        buserr_WB,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_accesses
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [15:0] TIMEOUT_VAL = TIMEOUT_CYCLES[15:0];

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        mem_op, misaligned, access, abort, req_int;
    logic [1:0]  lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign lane   = aluresult_MEM[1:0];
    assign mem_op = memread_MEM | memwrite_MEM;

    // Branch decision is purely combinational and ignores stalls.
    assign pcsrc_MEM    = branch_MEM & zero_MEM;
    assign pctarget_MEM = pcbranch_MEM;

    // Alignment check by access size; size 11 behaves as word.
    always_comb begin
        misaligned = 1'b0;
        case (memsize_MEM)
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = (lane != 2'b00);
        endcase
    end

    assign access = mem_op & ~misaligned;

    // Little-endian lane steering: byte enables and replicated store data.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = writedata_MEM;
        case (memsize_MEM)
            2'b01: begin
                dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{writedata_MEM[15:0]}};
            end
            2'b10: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {4{writedata_MEM[7:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = writedata_MEM;
            end
        endcase
    end

    // Load lane select and sign/zero extension.
    always_comb begin
        byte_sel = 8'h00;
        case (lane)
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel  = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_data = dmem_rdata;
        case (memsize_MEM)
            2'b01:   load_data = memsigned_MEM ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
            2'b10:   load_data = memsigned_MEM ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // FSM state and wait-cycle counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // FSM next state, request generation and timeout abort detection.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_int   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                req_int = access;
                if (access && !dmem_ack) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 16'd1;
                end
            end
            WAIT: begin
                req_int = 1'b1;
                if (dmem_ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 16'd0;
                end else if (cnt == TIMEOUT_VAL) begin
                    abort     = 1'b1;
                    req_int   = 1'b0;
                    state_nxt = IDLE;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Request is killed immediately while reset is asserted.
    assign dmem_req  = req_int & reset;
    assign dmem_we   = dmem_req & memwrite_MEM;
    assign dmem_addr = {aluresult_MEM[31:2], 2'b00};
    assign stall_MEM = dmem_req & ~dmem_ack;

    // MEM/WB register: bubble while stalled, otherwise capture the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_WB  <= 1'b0;
            memtoreg_WB  <= 1'b0;
            readdata_WB  <= 32'h0;
            aluresult_WB <= 32'h0;
            writereg_WB  <= 5'd0;
            misalign_WB  <= 1'b0;
            buserr_WB    <= 1'b0;
        end else if (stall_MEM) begin
            regwrite_WB <= 1'b0;
            misalign_WB <= 1'b0;
            buserr_WB   <= 1'b0;
        end else begin
            regwrite_WB  <= regwrite_MEM & ~(mem_op & misaligned) & ~abort;
            memtoreg_WB  <= memtoreg_MEM;
            readdata_WB  <= memread_MEM ? load_data : 32'h0;
            aluresult_WB <= aluresult_MEM;
            writereg_WB  <= writereg_MEM;
            misalign_WB  <= mem_op & misaligned;
            buserr_WB    <= abort;
        end
    end

`ifdef MEM_PERF_CNT_EN
    // Performance counters: stall cycles and completed bus accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stalls   <= 32'h0;
            perf_accesses <= 32'h0;
        end else begin
            if (stall_MEM)
                perf_stalls <= perf_stalls + 32'h1;
            if (dmem_req && dmem_ack)
                perf_accesses <= perf_accesses + 32'h1;
        end
    end
`else
    assign perf_stalls   = 32'h0;
    assign perf_accesses = 32'h0;
`endif

endmodule
